clock_monitor: RTL and testbench
================================

Name: clock_monitor

Overview:
- Synthesizable measurement block for the far end of a generated clock.
- Samples an asynchronous monitored clock in the system clock domain and measures its start delay after enable, its period and its high time, all in system-clock cycles.
- Flags out-of-range periods and stuck (stopped) clocks.
- Used in-system and in benches to check clock generators against their FREQ/PHASE/DUTY settings.

Parameters:
- CNT_W, 16: width of all counters and measurement outputs.
- SYNC_STAGES, 2: synchronizer flops on mon_clk; minimum 2.
- TIMEOUT, 1024: cycles without any detected mon_clk edge before stuck asserts. Must be less than 2^CNT_W-1.
- MIN_PERIOD, 4: lowest period, inclusive, for in_range.
- MAX_PERIOD, 1000: highest period, inclusive, for in_range.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- rst, input, 1: synchronous active-high reset.
- enable, input, 1: level; measurement runs while high. Synchronous to clk.
- mon_clk, input, 1: monitored clock; asynchronous.
- start_dly, output, CNT_W: cycles from enable to first detected mon_clk rise.
- period, output, CNT_W: last measured rise-to-rise interval.
- high_time, output, CNT_W: rise-to-fall interval belonging to that period.
- meas_valid, output, 1: one-cycle pulse when period and high_time update.
- in_range, output, 1: MIN_PERIOD <= period <= MAX_PERIOD. Updated with meas_valid.
- stuck, output, 1: no mon_clk edge for TIMEOUT cycles.
- stuck_level, output, 1: synchronized mon_clk level when stuck asserted.

Behaviour:
- **Reset:** all outputs 0, counters 0, synchronizer and edge-history flops 0, FSM to IDLE. Reset mid-measurement discards partial counts.
- **Edge detection:**
  - mon_clk passes through SYNC_STAGES flops; the last stage is registered again as prev.
  - rise = sync & ~prev; fall = ~sync & prev. Both are combinational and act at the next clk edge.
  - The synchronizer runs in every state.
- **Counter:** one cnt register, CNT_W bits. Increments by 1 per cycle in non-IDLE states and saturates at all-ones (no wrap).
- **FSM states:**
  - IDLE: cnt=0. enable=1 -> ARM.
  - ARM: cnt counts.
    - rise -> start_dly<=cnt (first ARM entry after enable only), cnt<=0, -> HIGH.
    - start_dly convention: if mon_clk is first sampled high m edges after the edge where enable was sampled, start_dly = m + SYNC_STAGES - 1.
  - HIGH: fall -> hold_high<=cnt+1, cnt keeps counting, -> LOW.
  - LOW: rise -> period<=cnt+1, high_time<=hold_high, in_range updated, meas_valid=1 for one cycle, cnt<=0, -> HIGH.
  - Detection latency cancels, so a clock of N cycles with H cycles high yields period=N, high_time=H. The first meas_valid comes at the second detected rise.
- **Timeout:**
  - An idle counter clears on any rise/fall and increments otherwise in ARM/HIGH/LOW.
  - When it reaches TIMEOUT: stuck<=1, stuck_level<=sync, cnt<=0, FSM -> ARM. start_dly is not re-captured.
  - stuck clears on the next detected rise.
  - No meas_valid is issued for the broken period; period, high_time and in_range hold.
- **enable=0 (sampled):**
  - Any state -> IDLE next cycle; cnt and timeout counter cleared; stuck cleared.
  - start_dly, period, high_time and in_range hold; meas_valid=0.
  - Re-enable re-captures start_dly.
- **Simultaneous events:**
  - enable=0 has priority over rise/fall/timeout.
  - rst has priority over everything.
  - An edge in the same cycle the timeout would fire wins, and the timeout does not fire.
- **Saturation:** a saturated cnt is latched as all-ones; in_range is then 0 unless MAX_PERIOD >= 2^CNT_W-1.
- **Limits:** mon_clk high or low for under 1 clk cycle may be missed. Only periods >= 2 cycles with both phases >= 1 cycle are guaranteed.

Test Plan:
- **Basic measurement:** rst 2 cycles, enable=1, mon_clk period 10 cycles, high 3 -> meas_valid every 10 cycles from the 2nd rise; period=10, high_time=3, in_range=1, stuck=0.
- **Start delay:** SYNC_STAGES=2, mon_clk first sampled high 10 edges after enable sampled -> start_dly=11; unchanged across later periods.
- **Out of range:** mon_clk period 3 (high 1), then period 1200 (high 600) -> in_range=0 in both; period=3 then 1200; high_time=1 then 600.
- **Stuck clock:** TIMEOUT=64, mon_clk stops high after a rise -> stuck=1 exactly 64 cycles after the last detected edge, stuck_level=1, no meas_valid.
  - Restart with period 10 -> stuck clears at the first rise; meas_valid resumes one period later.
- **Enable drop:** enable=0 mid-HIGH -> FSM IDLE next cycle, no meas_valid, outputs hold.
  - Re-enable -> new start_dly captured; first valid after two rises.
- **Reset mid-LOW:** rst during a measurement -> all outputs 0 the next cycle; no meas_valid for the partial period.

Source files
------------

// File: rtl/clock_monitor.sv
// Measures start delay, period and high time of an asynchronous clock in clk cycles,
// and flags out-of-range periods and a stopped clock.
module clock_monitor #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned MIN_PERIOD  = 4,
  parameter int unsigned MAX_PERIOD  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mon_clk,
  output logic [CNT_W-1:0] start_dly,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             in_range,
  output logic             stuck,
  output logic             stuck_level
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  // Range limits folded to CNT_W bits; a MAX_PERIOD at or beyond all-ones admits a saturated period.
  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam bit               MIN_OK  = 64'(MIN_PERIOD) <= CNT_MAX;
  localparam logic [CNT_W-1:0] MIN_P   = MIN_OK ? CNT_W'(MIN_PERIOD) : '1;
  localparam logic [CNT_W-1:0] MAX_P   = (64'(MAX_PERIOD) >= CNT_MAX) ? '1 : CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;
  logic                   sync_lvl;
  logic                   rise;
  logic                   fall;
  logic                   tmo_hit;
  logic                   start_pend;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_inc;
  logic [CNT_W-1:0]       tcnt;
  logic [CNT_W-1:0]       hold_high;

  function automatic logic in_rng(input logic [CNT_W-1:0] p);
    return MIN_OK && (p >= MIN_P) && (p <= MAX_P);
  endfunction

  always_comb begin
    sync_lvl = sync_q[SYNC_STAGES-1];
    rise     = sync_lvl & ~prev;
    fall     = ~sync_lvl & prev;
    cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
    tmo_hit  = ~(rise | fall) && (tcnt == TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mon_clk};
      prev   <= sync_lvl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      tcnt        <= '0;
      hold_high   <= '0;
      start_pend  <= 1'b0;
      start_dly   <= '0;
      period      <= '0;
      high_time   <= '0;
      meas_valid  <= 1'b0;
      in_range    <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
        tcnt  <= '0;
        stuck <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt        <= '0;
            tcnt       <= '0;
            start_pend <= 1'b1;
            state      <= ARM;
          end
          default: begin
            cnt  <= cnt_inc;
            tcnt <= (rise | fall) ? '0 : tcnt + 1'b1;
            if (rise) stuck <= 1'b0;
            // A timeout abandons the current period and re-arms without touching start_dly.
            if (tmo_hit) begin
              stuck       <= 1'b1;
              stuck_level <= sync_lvl;
              cnt         <= '0;
              tcnt        <= '0;
              state       <= ARM;
            end else begin
              case (state)
                ARM: if (rise) begin
                  if (start_pend) begin
                    start_dly  <= cnt;
                    start_pend <= 1'b0;
                  end
                  cnt   <= '0;
                  state <= HIGH;
                end
                HIGH: if (fall) begin
                  hold_high <= cnt_inc;
                  state     <= LOW;
                end
                LOW: if (rise) begin
                  period     <= cnt_inc;
                  high_time  <= hold_high;
                  in_range   <= in_rng(cnt_inc);
                  meas_valid <= 1'b1;
                  cnt        <= '0;
                  state      <= HIGH;
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: two instances (TIMEOUT 1024 and 64) share stimulus and are checked
// every cycle against an event/timestamp model, plus hand-computed spot values.
module tb_clock_monitor;

  localparam int CW   = 16;
  localparam int SS   = 2;
  localparam int TO0  = 1024;
  localparam int TO1  = 64;
  localparam int MINP = 4;
  localparam int MAXP = 1000;
  localparam int SATV = 65535;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic mon_clk = 1'b0;

  logic [CW-1:0] sd [2];
  logic [CW-1:0] pe [2];
  logic [CW-1:0] ht [2];
  logic          mv [2];
  logic          ir [2];
  logic          st [2];
  logic          sl [2];

  int checks = 0;
  int errors = 0;
  int vcnt [2];

  clock_monitor #(.CNT_W(CW), .SYNC_STAGES(SS), .TIMEOUT(TO0), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .mon_clk(mon_clk),
    .start_dly(sd[0]), .period(pe[0]), .high_time(ht[0]), .meas_valid(mv[0]),
    .in_range(ir[0]), .stuck(st[0]), .stuck_level(sl[0]));

  clock_monitor #(.CNT_W(CW), .SYNC_STAGES(SS), .TIMEOUT(TO1), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .mon_clk(mon_clk),
    .start_dly(sd[1]), .period(pe[1]), .high_time(ht[1]), .meas_valid(mv[1]),
    .in_range(ir[1]), .stuck(st[1]), .stuck_level(sl[1]));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an edge on the sample taken at edge k is acted on at edge k+SS; intervals are timestamp differences.
  bit hist [8];
  int t = 0;
  bit m_on [2], m_pend [2], m_hr [2], m_hf [2];
  int m_arm [2], m_rt [2], m_ft [2], m_ref [2];
  int m_sd [2], m_pe [2], m_ht [2];
  bit m_mv [2], m_ir [2], m_st [2], m_sl [2];

  function automatic int sat(input int x);
    return (x > SATV) ? SATV : x;
  endfunction

  task automatic step(input int i, input bit rs, input bit fl, input bit cur);
    int tmo;
    tmo = (i == 0) ? TO0 : TO1;
    m_mv[i] = 1'b0;
    if (rst) begin
      m_on[i] = 0; m_pend[i] = 0; m_hr[i] = 0; m_hf[i] = 0;
      m_sd[i] = 0; m_pe[i] = 0; m_ht[i] = 0; m_ir[i] = 0; m_st[i] = 0; m_sl[i] = 0;
    end else if (!m_on[i]) begin
      if (enable) begin
        m_on[i] = 1; m_pend[i] = 1; m_arm[i] = t; m_ref[i] = t; m_hr[i] = 0; m_hf[i] = 0;
      end
    end else if (!enable) begin
      m_on[i] = 0;
      m_st[i] = 0;
    end else if (rs) begin
      m_st[i] = 0;
      m_ref[i] = t;
      if (!m_hr[i]) begin
        if (m_pend[i]) begin
          m_sd[i] = sat(t - m_arm[i] - 1);
          m_pend[i] = 0;
        end
      end else if (m_hf[i]) begin
        m_mv[i] = 1;
        m_pe[i] = sat(t - m_rt[i]);
        m_ht[i] = sat(m_ft[i] - m_rt[i]);
        m_ir[i] = (m_pe[i] >= MINP) && (m_pe[i] <= MAXP);
      end
      m_hr[i] = 1; m_hf[i] = 0; m_rt[i] = t;
    end else if (fl) begin
      m_ref[i] = t;
      if (m_hr[i] && !m_hf[i]) begin
        m_hf[i] = 1;
        m_ft[i] = t;
      end
    end else if (t - m_ref[i] == tmo) begin
      m_st[i] = 1; m_sl[i] = cur; m_ref[i] = t;
      m_hr[i] = 0; m_hf[i] = 0; m_arm[i] = t;
    end
  endtask

  always @(posedge clk) begin
    bit cur, prv;
    t++;
    cur = hist[SS-1];
    prv = hist[SS];
    for (int k = 7; k > 0; k--) hist[k] = rst ? 1'b0 : hist[k-1];
    hist[0] = rst ? 1'b0 : mon_clk;
    for (int i = 0; i < 2; i++) step(i, cur & ~prv, ~cur & prv, cur);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("start_dly[%0d]", i), 32'(sd[i]), 32'(m_sd[i]));
      chk($sformatf("period[%0d]", i), 32'(pe[i]), 32'(m_pe[i]));
      chk($sformatf("high_time[%0d]", i), 32'(ht[i]), 32'(m_ht[i]));
      chk($sformatf("meas_valid[%0d]", i), 32'(mv[i]), 32'(m_mv[i]));
      chk($sformatf("in_range[%0d]", i), 32'(ir[i]), 32'(m_ir[i]));
      chk($sformatf("stuck[%0d]", i), 32'(st[i]), 32'(m_st[i]));
      chk($sformatf("stuck_level[%0d]", i), 32'(sl[i]), 32'(m_sl[i]));
      if (mv[i] === 1'b1) vcnt[i]++;
    end
  end

  task automatic run_clk(input int n, input int h, input int reps);
    for (int r = 0; r < reps; r++)
      for (int c = 0; c < n; c++) begin
        mon_clk = (c < h);
        @(negedge clk);
      end
  endtask

  task automatic clr_vcnt();
    vcnt[0] = 0;
    vcnt[1] = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_period", 32'(pe[0]), 32'd0);
    chk("rst_stuck", 32'(st[1]), 32'd0);

    // basic measurement with a 10-edge start delay
    rst = 1'b0;
    enable = 1'b1;
    clr_vcnt();
    repeat (10) @(negedge clk);
    run_clk(10, 3, 6);
    chk("basic_start_dly", 32'(sd[0]), 32'd11);
    chk("basic_start_dly_t", 32'(sd[1]), 32'd11);
    chk("basic_period", 32'(pe[0]), 32'd10);
    chk("basic_high", 32'(ht[0]), 32'd3);
    chk("basic_in_range", 32'(ir[0]), 32'd1);
    chk("basic_valid_cnt", 32'(vcnt[0]), 32'd5);
    chk("basic_valid_cnt_t", 32'(vcnt[1]), 32'd5);

    // out of range, both sides, then range boundaries
    run_clk(3, 1, 4);
    chk("short_period", 32'(pe[0]), 32'd3);
    chk("short_high", 32'(ht[0]), 32'd1);
    chk("short_in_range", 32'(ir[0]), 32'd0);
    run_clk(1200, 600, 2);
    chk("long_period", 32'(pe[0]), 32'd1200);
    chk("long_high", 32'(ht[0]), 32'd600);
    chk("long_in_range", 32'(ir[0]), 32'd0);
    chk("long_start_dly", 32'(sd[0]), 32'd11);
    run_clk(4, 2, 3);
    chk("min_in_range", 32'(ir[0]), 32'd1);
    run_clk(1000, 500, 2);
    chk("max_period", 32'(pe[0]), 32'd1000);
    chk("max_in_range", 32'(ir[0]), 32'd1);
    run_clk(1001, 500, 2);
    chk("over_in_range", 32'(ir[0]), 32'd0);

    // stuck high, then restart
    run_clk(10, 3, 3);
    mon_clk = 1'b1;
    repeat (200) @(negedge clk);
    chk("stuck_t", 32'(st[1]), 32'd1);
    chk("stuck_level_t", 32'(sl[1]), 32'd1);
    chk("stuck_long_to", 32'(st[0]), 32'd0);
    run_clk(10, 3, 3);
    chk("stuck_cleared", 32'(st[1]), 32'd0);
    chk("restart_period", 32'(pe[1]), 32'd10);

    // enable drop mid-HIGH, then re-enable
    mon_clk = 1'b1;
    repeat (3) @(negedge clk);
    clr_vcnt();
    enable = 1'b0;
    run_clk(10, 3, 2);
    chk("drop_valid_cnt", 32'(vcnt[0]), 32'd0);
    chk("drop_period_hold", 32'(pe[0]), 32'd10);
    enable = 1'b1;
    clr_vcnt();
    repeat (4) @(negedge clk);
    run_clk(10, 3, 3);
    chk("reen_start_dly", 32'(sd[0]), 32'd5);
    chk("reen_start_dly_t", 32'(sd[1]), 32'd5);
    chk("reen_valid_cnt", 32'(vcnt[0]), 32'd2);

    // reset in the LOW phase
    mon_clk = 1'b1;
    repeat (3) @(negedge clk);
    mon_clk = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_period", 32'(pe[0]), 32'd0);
    chk("rstmid_start_dly", 32'(sd[0]), 32'd0);
    chk("rstmid_high", 32'(ht[1]), 32'd0);
    rst = 1'b0;
    run_clk(10, 3, 3);
    chk("post_rst_start_dly", 32'(sd[0]), 32'd1);
    chk("post_rst_period", 32'(pe[0]), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
